// File: rtl/fb_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fb_access_scheduler
// Purpose  : Owns the single-port synchronous framebuffer RAM and hands out
//            one access slot per clock. Priority: display fetch > frame-clear
//            engine > game writers A/B (round-robin between the two writers).
// Ports    :
//   iCLK, iRST_N                 clock, asynchronous active-low reset
//   iRequest, iPixel_x/y         display fetch request and raster position
//   iFrameStart                  start-of-vblank pulse (starts an armed clear)
//   oPixData, oPixValid          fetched pixel, valid 3 cycles after iRequest
//   iWrX_req/addr/data, oWrX_ack writer ports A and B (request held to ack)
//   iClear_go, iClear_color      arm a full-frame clear with a fill colour
//   oClear_busy, oClear_done     clear in progress / one-cycle completion
//   oRam_addr/wdata/we           registered RAM command
//   iRam_rdata                   RAM read data, one cycle after the address
// Revision : 1.0 - initial release
// ============================================================================
module fb_access_scheduler #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iRequest,
  input  logic [9:0]        iPixel_x,
  input  logic [9:0]        iPixel_y,
  input  logic              iFrameStart,
  output logic [DATA_W-1:0] oPixData,
  output logic              oPixValid,
  input  logic              iWrA_req,
  input  logic [ADDR_W-1:0] iWrA_addr,
  input  logic [DATA_W-1:0] iWrA_data,
  output logic              oWrA_ack,
  input  logic              iWrB_req,
  input  logic [ADDR_W-1:0] iWrB_addr,
  input  logic [DATA_W-1:0] iWrB_data,
  output logic              oWrB_ack,
  input  logic              iClear_go,
  input  logic [DATA_W-1:0] iClear_color,
  output logic              oClear_busy,
  output logic              oClear_done,
  output logic [ADDR_W-1:0] oRam_addr,
  output logic [DATA_W-1:0] oRam_wdata,
  output logic              oRam_we,
  input  logic [DATA_W-1:0] iRam_rdata
);

  localparam logic [ADDR_W:0]   c_FB_SIZE   = (ADDR_W+1)'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_req_d;       // iRequest one cycle ago (rise detect)
  logic [ADDR_W-1:0]   r_last_addr;   // last display read address issued
  logic                r_last_valid;
  logic                r_rd_d1;       // read issued 1 / 2 cycles ago
  logic                r_rd_d2;
  logic [2:0]          r_valid_pipe;
  logic                r_last_b;      // 1: writer B was granted most recently
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [DATA_W-1:0]   r_clr_color;

  logic [ADDR_W-1:0]   w_disp_addr;
  logic                w_disp_rd;
  logic                w_clr_wr;
  logic                w_clr_done;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_a_in_range;
  logic                w_b_in_range;

  assign w_disp_addr = ADDR_W'(iPixel_y >> SCALE_SH) * ADDR_W'(FB_W)
                     + ADDR_W'(iPixel_x >> SCALE_SH);

  // Several raster pixels map to one framebuffer word; only re-read when the
  // word changes or a new request burst starts, leaving spare slots for writes.
  assign w_disp_rd = iRequest &&
                     (!r_last_valid || (w_disp_addr != r_last_addr) || !r_req_d);

  assign w_a_in_range = ({1'b0, iWrA_addr} < c_FB_SIZE);
  assign w_b_in_range = ({1'b0, iWrB_addr} < c_FB_SIZE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_wr    = 1'b0;
    w_clr_done  = 1'b0;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A go coinciding with iFrameStart only arms; the clear waits for the
        // next frame start.
        if (iClear_go) begin
          w_state_nxt = S_ARM;
        end
        if (!w_disp_rd) begin
          if (iWrA_req && (!iWrB_req || r_last_b)) begin
            w_grant_a = 1'b1;
          end else if (iWrB_req) begin
            w_grant_b = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (iFrameStart) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!w_disp_rd) begin
          w_clr_wr = 1'b1;
          if (r_clr_cnt == c_LAST_ADDR) begin
            w_clr_done  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_req_d      <= 1'b0;
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
      r_rd_d1      <= 1'b0;
      r_rd_d2      <= 1'b0;
      r_valid_pipe <= '0;
      r_last_b     <= 1'b1;
      r_clr_cnt    <= '0;
      r_clr_color  <= '0;
      oPixData     <= '0;
      oWrA_ack     <= 1'b0;
      oWrB_ack     <= 1'b0;
      oClear_busy  <= 1'b0;
      oClear_done  <= 1'b0;
      oRam_addr    <= '0;
      oRam_wdata   <= '0;
      oRam_we      <= 1'b0;
    end else begin
      r_req_d      <= iRequest;
      r_rd_d1      <= w_disp_rd;
      r_rd_d2      <= r_rd_d1;
      r_valid_pipe <= {r_valid_pipe[1:0], iRequest};
      // Address registered at +1, RAM data returns at +2, captured at +3.
      if (r_rd_d2) begin
        oPixData <= iRam_rdata;
      end
      if (w_disp_rd) begin
        r_last_addr  <= w_disp_addr;
        r_last_valid <= 1'b1;
      end

      oRam_we <= 1'b0;
      if (w_disp_rd) begin
        oRam_addr <= w_disp_addr;
      end else if (w_clr_wr) begin
        oRam_addr  <= r_clr_cnt;
        oRam_wdata <= r_clr_color;
        oRam_we    <= 1'b1;
      end else if (w_grant_a) begin
        oRam_addr  <= iWrA_addr;
        oRam_wdata <= iWrA_data;
        oRam_we    <= w_a_in_range;
      end else if (w_grant_b) begin
        oRam_addr  <= iWrB_addr;
        oRam_wdata <= iWrB_data;
        oRam_we    <= w_b_in_range;
      end

      oWrA_ack <= w_grant_a;
      oWrB_ack <= w_grant_b;
      if (w_grant_a) begin
        r_last_b <= 1'b0;
      end else if (w_grant_b) begin
        r_last_b <= 1'b1;
      end

      if (r_state == S_IDLE && iClear_go) begin
        r_clr_color <= iClear_color;
        oClear_busy <= 1'b1;
      end
      if (r_state == S_ARM && iFrameStart) begin
        r_clr_cnt <= '0;
      end
      if (w_clr_wr) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      oClear_done <= w_clr_done;
      if (w_clr_done) begin
        oClear_busy <= 1'b0;
      end
    end
  end

  assign oPixValid = r_valid_pipe[2];

endmodule
`default_nettype wire

// File: tb/tb_fb_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_access_scheduler
// Purpose  : Self-checking bench for fb_access_scheduler. A slot-level model
//            predicts every registered output each cycle; directed sequences
//            pin latency, round-robin, preemption, range drop, clear and
//            reset-abandon behaviour with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_access_scheduler;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 15;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;

  logic              iCLK = 1'b0;
  logic              iRST_N = 1'b0;
  logic              iRequest = 1'b0;
  logic [9:0]        iPixel_x = '0;
  logic [9:0]        iPixel_y = '0;
  logic              iFrameStart = 1'b0;
  logic [DATA_W-1:0] oPixData;
  logic              oPixValid;
  logic              iWrA_req = 1'b0;
  logic [ADDR_W-1:0] iWrA_addr = '0;
  logic [DATA_W-1:0] iWrA_data = '0;
  logic              oWrA_ack;
  logic              iWrB_req = 1'b0;
  logic [ADDR_W-1:0] iWrB_addr = '0;
  logic [DATA_W-1:0] iWrB_data = '0;
  logic              oWrB_ack;
  logic              iClear_go = 1'b0;
  logic [DATA_W-1:0] iClear_color = '0;
  logic              oClear_busy;
  logic              oClear_done;
  logic [ADDR_W-1:0] oRam_addr;
  logic [DATA_W-1:0] oRam_wdata;
  logic              oRam_we;
  logic [DATA_W-1:0] iRam_rdata;

  always #5 iCLK = ~iCLK;

  fb_access_scheduler #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FB_W(FB_W), .FB_H(FB_H), .SCALE_SH(2)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRequest(iRequest),
    .iPixel_x(iPixel_x), .iPixel_y(iPixel_y), .iFrameStart(iFrameStart),
    .oPixData(oPixData), .oPixValid(oPixValid),
    .iWrA_req(iWrA_req), .iWrA_addr(iWrA_addr), .iWrA_data(iWrA_data), .oWrA_ack(oWrA_ack),
    .iWrB_req(iWrB_req), .iWrB_addr(iWrB_addr), .iWrB_data(iWrB_data), .oWrB_ack(oWrB_ack),
    .iClear_go(iClear_go), .iClear_color(iClear_color),
    .oClear_busy(oClear_busy), .oClear_done(oClear_done),
    .oRam_addr(oRam_addr), .oRam_wdata(oRam_wdata), .oRam_we(oRam_we),
    .iRam_rdata(iRam_rdata)
  );

  // Synchronous single-port RAM behind the scheduler
  logic [DATA_W-1:0] ram [0:32767];
  always @(posedge iCLK) begin
    if (oRam_we) ram[oRam_addr] <= oRam_wdata;
    iRam_rdata <= ram[oRam_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one step per slot) ----------------
  logic [DATA_W-1:0] mem [0:32767];
  int          m_mode;          // 0 idle, 1 waiting for frame start, 2 clearing
  int          m_idx;
  logic [7:0]  m_color;
  bit          m_prefer_a = 1'b1;
  bit          m_have_last;
  int          m_last;
  bit          m_prev_req;
  bit          m_pend_we;
  int          m_pend_addr;
  logic [7:0]  m_pend_data;
  bit          req_h [3];
  bit          rd_h [3];
  logic [7:0]  dat_h [3];
  int          m_disp, m_old_mode;
  bit          m_rd, m_take_a;
  bit          e_we, e_rd, e_acka, e_ackb, e_busy, e_done, e_valid;
  int          e_addr;
  logic [7:0]  e_wdata;
  logic [7:0]  e_pix = 8'h00;

  always @(posedge iCLK) begin
    if (!iRST_N) begin
      m_mode = 0; m_idx = 0; m_prefer_a = 1'b1; m_have_last = 1'b0;
      m_prev_req = 1'b0; m_pend_we = 1'b0;
      for (int i = 0; i < 3; i++) begin req_h[i] = 0; rd_h[i] = 0; dat_h[i] = 0; end
      e_we = 0; e_rd = 0; e_acka = 0; e_ackb = 0; e_busy = 0; e_done = 0;
      e_valid = 0; e_pix = 8'h00; e_addr = 0;
    end else begin
      // the write granted last slot lands in the RAM at this edge
      if (m_pend_we) mem[m_pend_addr] = m_pend_data;
      m_pend_we = 1'b0;
      m_disp = ((int'(iPixel_y) / 4) * FB_W + int'(iPixel_x) / 4) % 32768;
      m_rd = iRequest && (!m_have_last || m_disp != m_last || !m_prev_req);
      m_prev_req = iRequest;
      m_old_mode = m_mode;
      e_we = 0; e_rd = m_rd; e_acka = 0; e_ackb = 0; e_done = 0;
      if (m_rd) begin
        m_have_last = 1'b1; m_last = m_disp; e_addr = m_disp;
      end else if (m_old_mode == 2) begin
        e_we = 1; e_addr = m_idx; e_wdata = m_color; m_idx++;
        if (m_idx == FB_SIZE) begin e_done = 1; e_busy = 0; m_mode = 0; end
      end else if (m_old_mode == 0 && (iWrA_req || iWrB_req)) begin
        m_take_a = iWrA_req && (!iWrB_req || m_prefer_a);
        e_acka = m_take_a; e_ackb = !m_take_a; m_prefer_a = !m_take_a;
        e_addr  = m_take_a ? int'(iWrA_addr) : int'(iWrB_addr);
        e_wdata = m_take_a ? iWrA_data : iWrB_data;
        e_we = (e_addr < FB_SIZE);
      end
      if (e_we) begin m_pend_we = 1; m_pend_addr = e_addr; m_pend_data = e_wdata; end
      if (m_old_mode == 0 && iClear_go) begin
        m_mode = 1; e_busy = 1; m_color = iClear_color;
      end else if (m_old_mode == 1 && iFrameStart) begin
        m_mode = 2; m_idx = 0;
      end
      req_h[2] = req_h[1]; req_h[1] = req_h[0]; req_h[0] = iRequest;
      rd_h[2] = rd_h[1];   rd_h[1] = rd_h[0];   rd_h[0] = m_rd;
      dat_h[2] = dat_h[1]; dat_h[1] = dat_h[0]; dat_h[0] = m_rd ? mem[m_disp] : 8'h00;
      e_valid = req_h[2];
      if (rd_h[2]) e_pix = dat_h[2];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge iCLK) begin
    if (!iRST_N) begin
      chk("rst_we", oRam_we, 0);
      chk("rst_addr", oRam_addr, 0);
      chk("rst_busy", oClear_busy, 0);
      chk("rst_done", oClear_done, 0);
      chk("rst_valid", oPixValid, 0);
      chk("rst_acks", {oWrA_ack, oWrB_ack}, 0);
    end else begin
      chk("we", oRam_we, e_we);
      chk("ackA", oWrA_ack, e_acka);
      chk("ackB", oWrB_ack, e_ackb);
      chk("busy", oClear_busy, e_busy);
      chk("done", oClear_done, e_done);
      chk("pixvalid", oPixValid, e_valid);
      chk("pixdata", oPixData, e_pix);
      if (e_we || e_rd) chk("ram_addr", oRam_addr, e_addr);
      if (e_we) chk("ram_wdata", oRam_wdata, e_wdata);
    end
  end

  // ---------------- stimulus ----------------
  bit rand_disp = 0;
  bit rand_wr = 0;

  task automatic tick();
    @(posedge iCLK); #1;
    if (rand_disp) begin
      if ($urandom_range(0, 15) == 0) iRequest = ~iRequest;
      iPixel_x = (iPixel_x == 10'd639) ? 10'd0 : iPixel_x + 10'd1;
      if ($urandom_range(0, 7) == 0) iPixel_x = 10'($urandom_range(0, 639));
      if ($urandom_range(0, 63) == 0) iPixel_y = 10'($urandom_range(0, 479));
    end
    if (rand_wr) begin
      if (!iWrA_req || oWrA_ack) begin
        iWrA_req  = ($urandom_range(0, 2) != 0);
        iWrA_addr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(19200, 32767))
                                                  : ADDR_W'($urandom_range(0, 19199));
        iWrA_data = DATA_W'($urandom);
      end
      if (!iWrB_req || oWrB_ack) begin
        iWrB_req  = ($urandom_range(0, 2) != 0);
        iWrB_addr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(19200, 32767))
                                                  : ADDR_W'($urandom_range(0, 19199));
        iWrB_data = DATA_W'($urandom);
      end
    end
  endtask

  int n_wr, n_ack, n_done, nxt_addr, bad_seq, seen;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i] = DATA_W'($urandom);
      mem[i] = ram[i];
    end
    ram[0] = 8'hA5; mem[0] = 8'hA5;
    ram[1] = 8'h5A; mem[1] = 8'h5A;

    repeat (3) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    chk("reset_busy", oClear_busy, 0);
    chk("reset_pixvalid", oPixValid, 0);

    // Round-robin: both writers held, A first after reset
    iWrA_req = 1; iWrA_addr = 15'd100; iWrA_data = 8'h11;
    iWrB_req = 1; iWrB_addr = 15'd200; iWrB_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_ackA", oWrA_ack, (k % 2 == 0));
      chk("rr_ackB", oWrB_ack, (k % 2 == 1));
      chk("rr_we", oRam_we, 1);
    end
    iWrA_req = 0; iWrB_req = 0;
    tick();

    // Display latency: x = 0..7 on row 0
    iRequest = 1; iPixel_x = 0; iPixel_y = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) chk("disp_addr0", oRam_addr, 0);
      if (k == 2) begin chk("disp_hold_addr", oRam_addr, 0); chk("disp_valid_early", oPixValid, 0); end
      if (k == 3) begin chk("disp_valid3", oPixValid, 1); chk("disp_pix0", oPixData, 8'hA5); end
      if (k == 5) chk("disp_addr1", oRam_addr, 1);
      if (k == 6) chk("disp_pix_hold", oPixData, 8'hA5);
      if (k == 7) chk("disp_pix1", oPixData, 8'h5A);
      if (k < 8) iPixel_x = 10'(k); else iRequest = 0;
    end
    tick();

    // Out-of-range write is acked but dropped
    iWrA_req = 1; iWrA_addr = 15'd19200; iWrA_data = 8'h33;
    tick();
    chk("oor_ack", oWrA_ack, 1);
    chk("oor_we", oRam_we, 0);
    iWrA_req = 0;
    tick(); tick();

    // Display preempts writer A
    iRequest = 1; iPixel_x = 10'd16; iPixel_y = 0;
    iWrA_req = 1; iWrA_addr = 15'd300; iWrA_data = 8'h44;
    tick();
    chk("pre_noack", oWrA_ack, 0);
    chk("pre_rdaddr", oRam_addr, 4);
    chk("pre_we", oRam_we, 0);
    iPixel_x = 10'd17;
    tick();
    chk("pre_ack", oWrA_ack, 1);
    chk("pre_waddr", oRam_addr, 300);
    chk("pre_wwe", oRam_we, 1);
    iWrA_req = 0; iRequest = 0;
    tick();

    // Full clear, writer A held throughout
    iClear_go = 1; iClear_color = 8'h3C;
    tick();
    chk("clr_busy_rise", oClear_busy, 1);
    iClear_go = 0;
    iWrA_req = 1; iWrA_addr = 15'd500; iWrA_data = 8'h77;
    repeat (99) tick();
    iFrameStart = 1;
    tick();
    iFrameStart = 0;
    n_wr = 0; n_ack = 0; n_done = 0; nxt_addr = 0; bad_seq = 0; seen = 0;
    for (int c = 0; c < 25000 && !seen; c++) begin
      tick();
      if (oRam_we) begin
        if (int'(oRam_addr) != nxt_addr || oRam_wdata != 8'h3C) bad_seq++;
        nxt_addr++; n_wr++;
      end
      if (oWrA_ack) n_ack++;
      if (oClear_done) begin n_done++; seen = 1; end
    end
    chk("clr_done_seen", seen, 1);
    chk("clr_write_count", n_wr, FB_SIZE);
    chk("clr_seq_errors", bad_seq, 0);
    chk("clr_blocked_acks", n_ack, 0);
    chk("clr_busy_fall", oClear_busy, 0);
    tick();
    chk("clr_ackA_after", oWrA_ack, 1);
    iWrA_req = 0;
    repeat (4) begin
      tick();
      if (oClear_done) n_done++;
    end
    chk("clr_done_once", n_done, 1);

    // Reset in the middle of a clear
    iClear_go = 1; iClear_color = 8'h99;
    tick();
    iClear_go = 0;
    tick();
    iFrameStart = 1;
    tick();
    iFrameStart = 0;
    n_wr = 0;
    for (int c = 0; c < 8000 && n_wr < 5000; c++) begin
      tick();
      if (oRam_we) n_wr++;
    end
    chk("mid_reached", n_wr, 5000);
    iRST_N = 0;
    #1;
    chk("mid_rst_we", oRam_we, 0);
    chk("mid_rst_addr", oRam_addr, 0);
    chk("mid_rst_busy", oClear_busy, 0);
    chk("mid_rst_done", oClear_done, 0);
    tick(); tick();
    iRST_N = 1;
    n_done = 0;
    repeat (5) begin
      tick();
      if (oClear_done) n_done++;
    end
    chk("mid_no_done", n_done, 0);

    // New clear under random traffic; go together with frame start only arms
    rand_disp = 1; rand_wr = 1;
    iClear_go = 1; iFrameStart = 1; iClear_color = 8'hC3;
    tick();
    iClear_go = 0; iFrameStart = 0;
    repeat (3) tick();
    n_wr = 0;
    repeat (20) begin
      tick();
      if (oRam_we) n_wr++;
    end
    chk("arm_no_write", n_wr, 0);
    iFrameStart = 1;
    tick();
    iFrameStart = 0;
    seen = 0;
    for (int c = 0; c < 30000 && !seen; c++) begin
      tick();
      if (oClear_done) seen = 1;
    end
    chk("clr2_done_seen", seen, 1);

    repeat (3000) tick();
    rand_disp = 0; rand_wr = 0;
    iRequest = 0; iWrA_req = 0; iWrB_req = 0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
Owns the single-port synchronous framebuffer RAM and shares it among three requesters: the VGA display fetch, two game-logic write ports (A, B), and a built-in frame-clear engine. The framebuffer is FB_W x FB_H, upscaled by 2^SCALE_SH to the 640x480 raster. The block sits between the VGA timing controller, which supplies oRequest, pixel_x and pixel_y, and the colour LUT that consumes oPixData.

Parameters:
DATA_W, 8, framebuffer word width (colour index)
ADDR_W, 15, RAM address width
FB_W, 160, framebuffer width in words
FB_H, 120, framebuffer height in words
SCALE_SH, 2, raster-to-framebuffer shift (x>>SCALE_SH, y>>SCALE_SH)

Ports:
iCLK  in  1  clock
iRST_N  in  1  reset, asynchronous, active-low
iRequest  in  1  display fetch request from the VGA timing controller
iPixel_x  in  10  raster x
iPixel_y  in  10  raster y
iFrameStart  in  1  one-cycle pulse at the start of vertical blank
oPixData  out  DATA_W  fetched pixel
oPixValid  out  1  oPixData corresponds to iRequest from 3 cycles earlier
iWrA_req  in  1  writer A request, held until ack
iWrA_addr  in  ADDR_W  writer A address
iWrA_data  in  DATA_W  writer A data
oWrA_ack  out  1  one-cycle grant pulse
iWrB_req, iWrB_addr, iWrB_data, oWrB_ack  as writer A
iClear_go  in  1  pulse: arm a full-frame clear
iClear_color  in  DATA_W  fill value, sampled on the accepted iClear_go
oClear_busy  out  1  high from the accepted iClear_go until clear completes
oClear_done  out  1  one-cycle pulse after the last clear write
oRam_addr  out  ADDR_W  RAM address (registered)
oRam_wdata  out  DATA_W  RAM write data (registered)
oRam_we  out  1  RAM write enable (registered)
iRam_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address

Behaviour:
- Reset: every output 0; FSM IDLE; round-robin pointer "last=B", so A wins the first tie; last-read-address register invalid.
- Slot: one RAM access per cycle. Arbitration is evaluated combinationally; the winning access is registered onto oRam_* at the next edge; ack pulses are registered at that same edge.
- Display address: (iPixel_y>>SCALE_SH)*FB_W + (iPixel_x>>SCALE_SH), computed at ADDR_W width.
- Display fetch priority: highest.
  - A display read consumes the slot only when iRequest=1 and either the address differs from the last issued read address or iRequest rose this cycle.
  - Otherwise the slot is free for lower priorities, even while iRequest=1.
- Display output: oPixData updates only when a read was issued 2 cycles earlier; otherwise it holds. oPixValid is iRequest delayed by exactly 3 cycles. Fixed latency is 3.
- Priority order: display > clear engine > writers A/B.
- Writer round-robin:
  - If both writers request, grant the one not granted last.
  - A lone requester is granted immediately.
  - The pointer updates only on a grant.
- Out-of-range writes: a writer address >= FB_W*FB_H is acked but produces oRam_we=0 (dropped).
- Clear FSM:
  - IDLE: iClear_go latches iClear_color, sets oClear_busy=1 and moves to ARM.
  - ARM: waits for iFrameStart, then moves to CLEAR with the counter at 0.
  - CLEAR: on each slot not taken by the display, write the colour to the counter address and increment the counter. After address FB_W*FB_H-1 is written, pulse oClear_done and return to IDLE, with oClear_busy falling on the same edge.
- During ARM and CLEAR: writers receive no ack. iClear_go is ignored in any state other than IDLE.
- Simultaneous events:
  - iClear_go and iFrameStart in the same IDLE cycle: go to ARM only; wait for the next iFrameStart.
  - A writer request that is held through a display-read cycle stays pending, with no ack.
- Reset mid-clear: the FSM returns to IDLE and the clear is abandoned (no oClear_done); partial RAM contents remain.

Test Plan:
- Display latency: set x=0..7, y=0 with iRequest=1 held → reads are issued only at x=0 and x=4 (addresses 0 and 1); oPixValid rises 3 cycles after iRequest; oPixData equals RAM[0] for 4 pixels, then RAM[1].
- Round-robin: hold A and B continuously with iRequest=0 → acks alternate A,B,A,B, starting with A after reset; oRam_we=1 on every cycle.
- Display preemption: request A during a cycle where the display address changes → no ack that cycle; ack on the next free slot; the read address is issued first.
- Out-of-range write: A addr=19200 → oWrA_ack=1, oRam_we=0.
- Clear:
  - Stimulus: iClear_go with colour 0x3C, iFrameStart 100 cycles later, iRequest=0.
  - Response: oClear_busy high from the next edge; 19200 consecutive writes at addresses 0..19199 with data 0x3C; oClear_done pulses once; writer A is blocked throughout and acked on the first cycle after oClear_busy falls.
- Reset mid-clear: assert iRST_N low at counter=5000 → all outputs 0 and no oClear_done; a new iClear_go then works normally.
